// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: register address width, forward select
// encodings, multiply/divide timer states and the forward-select priority rule.
package hazard_unit_pkg;

    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // MEM wins over WB because it holds the younger result; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input reg_addr_t src,
                                           input reg_addr_t wr_m, input logic we_m,
                                           input reg_addr_t wr_w, input logic we_w);
        if (we_m && (wr_m != '0) && (wr_m == src)) return FWD_MEM;
        if (we_w && (wr_w != '0) && (wr_w == src)) return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side is the master,
// the hazard unit is the slave.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    reg_addr_t  rsD;
    reg_addr_t  rtD;
    reg_addr_t  writeRegAddrE;
    logic       regWriteE;
    logic       memToRegE;
    logic       branchTakenD;
    logic       mdStartD;
    logic       mdStartE;
    logic       hiloReadD;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       stallF;
    logic       stallD;
    logic       flushD;
    logic       flushE;
    logic       mdBusy;
    logic       mdDone;

    modport master (
        output rsD, rtD, writeRegAddrE, regWriteE, memToRegE, branchTakenD,
               mdStartD, mdStartE, hiloReadD,
        input  forwardAE, forwardBE, stallF, stallD, flushD, flushE, mdBusy, mdDone
    );

    modport slave (
        input  rsD, rtD, writeRegAddrE, regWriteE, memToRegE, branchTakenD,
               mdStartD, mdStartE, hiloReadD,
        output forwardAE, forwardBE, stallF, stallD, flushD, flushE, mdBusy, mdDone
    );

endinterface

// File: rtl/hazard_unit_md_timer.sv
// Multiply/divide occupancy timer: busy for MD_LATENCY cycles after start,
// done pulses on the last busy cycle. Starts while busy are ignored.
module md_timer
    import hazard_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(MD_LATENCY);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // done_q is raised one edge ahead so it lines up with the count==0 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= CNT_W'(MD_LATENCY - 1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        done_q <= (cnt_q == CNT_W'(1));
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding from shadowed M/W destinations,
// load-use and HI/LO stalls, branch flush, and multiply/divide occupancy.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    reg_addr_t rsE_q, rsE_d, rtE_q, rtE_d;
    reg_addr_t writeRegM_q, writeRegW_q;
    logic      regWriteM_q, regWriteW_q;
    logic      md_busy, md_done;
    logic      load_use, md_hazard, stall;

    assign load_use  = hz.regWriteE & hz.memToRegE & (hz.writeRegAddrE != '0) &
                       ((hz.writeRegAddrE == hz.rsD) | (hz.writeRegAddrE == hz.rtD));
    assign md_hazard = md_busy & (hz.hiloReadD | hz.mdStartD);
    assign stall     = load_use | md_hazard;

    // A flushed EX gets a bubble with source $0 so it can never match a forward.
    always_comb begin
        rsE_d = hz.rsD;
        rtE_d = hz.rtD;
        if (stall) begin
            rsE_d = '0;
            rtE_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsE_q       <= '0;
            rtE_q       <= '0;
            writeRegM_q <= '0;
            regWriteM_q <= 1'b0;
            writeRegW_q <= '0;
            regWriteW_q <= 1'b0;
        end else begin
            rsE_q       <= rsE_d;
            rtE_q       <= rtE_d;
            writeRegM_q <= hz.writeRegAddrE;
            regWriteM_q <= hz.regWriteE;
            writeRegW_q <= writeRegM_q;
            regWriteW_q <= regWriteM_q;
        end
    end

    logic [1:0][REG_W-1:0] src_e;
    logic [1:0][1:0]       fwd;

    assign src_e = {rtE_q, rsE_q};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        assign fwd[g] = fwd_sel(src_e[g], writeRegM_q, regWriteM_q, writeRegW_q, regWriteW_q);
    end

    md_timer #(.MD_LATENCY(MD_LATENCY)) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (hz.mdStartE),
        .busy  (md_busy),
        .done  (md_done)
    );

    assign hz.forwardAE = fwd[0];
    assign hz.forwardBE = fwd[1];
    assign hz.stallF    = stall;
    assign hz.stallD    = stall;
    assign hz.flushE    = stall;
    // A taken branch under stall re-presents itself once the stall drops.
    assign hz.flushD    = hz.branchTakenD & ~stall;
    assign hz.mdBusy    = md_busy;
    assign hz.mdDone    = md_done;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int LAT = 4;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    hazard_unit_if hz ();

    hazard_unit #(.MD_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.rsD = '0; hz.rtD = '0; hz.writeRegAddrE = '0;
        hz.regWriteE = 1'b0; hz.memToRegE = 1'b0; hz.branchTakenD = 1'b0;
        hz.mdStartD = 1'b0; hz.mdStartE = 1'b0; hz.hiloReadD = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        hz.branchTakenD = 1'b1;
        step(); step(); #1;
        checks++; if (hz.forwardAE !== 2'b00) begin fails++; $display("FAIL reset_fwdA: got %b exp 00", hz.forwardAE); end
        checks++; if (hz.forwardBE !== 2'b00) begin fails++; $display("FAIL reset_fwdB: got %b exp 00", hz.forwardBE); end
        checks++; if (hz.mdBusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", hz.mdBusy); end
        checks++; if (hz.mdDone !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", hz.mdDone); end
        checks++; if (hz.stallF !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b exp 0", hz.stallF); end
        checks++; if (hz.flushD !== 1'b1) begin fails++; $display("FAIL reset_flushD: got %b exp 1", hz.flushD); end
        hz.branchTakenD = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // add $3 in EX, consumer of $3 follows, then another consumer one cycle later
    task automatic test_forward_mem_wb();
        clear_inputs();
        hz.writeRegAddrE = 5'd3; hz.regWriteE = 1'b1; hz.rsD = 5'd3;
        step();
        hz.writeRegAddrE = 5'd0; hz.regWriteE = 1'b0; hz.rsD = 5'd3;
        #1;
        checks++; if (hz.forwardAE !== 2'b01) begin fails++; $display("FAIL fwd_mem_A: got %b exp 01", hz.forwardAE); end
        checks++; if (hz.forwardBE !== 2'b00) begin fails++; $display("FAIL fwd_mem_B: got %b exp 00", hz.forwardBE); end
        step();
        #1;
        checks++; if (hz.forwardAE !== 2'b10) begin fails++; $display("FAIL fwd_wb_A: got %b exp 10", hz.forwardAE); end
        clear_inputs();
        step(); step();
    endtask

    // $5 in both M and W: MEM wins; writes to $0 never forward
    task automatic test_priority_zero();
        clear_inputs();
        hz.writeRegAddrE = 5'd5; hz.regWriteE = 1'b1; hz.rsD = 5'd5; hz.rtD = 5'd5;
        step(); step(); #1;
        checks++; if (hz.forwardAE !== 2'b01) begin fails++; $display("FAIL prio_A: got %b exp 01", hz.forwardAE); end
        checks++; if (hz.forwardBE !== 2'b01) begin fails++; $display("FAIL prio_B: got %b exp 01", hz.forwardBE); end
        hz.writeRegAddrE = 5'd0; hz.rsD = 5'd0; hz.rtD = 5'd0;
        step(); step(); #1;
        checks++; if (hz.forwardAE !== 2'b00) begin fails++; $display("FAIL zero_A: got %b exp 00", hz.forwardAE); end
        checks++; if (hz.forwardBE !== 2'b00) begin fails++; $display("FAIL zero_B: got %b exp 00", hz.forwardBE); end
        clear_inputs();
        step(); step();
    endtask

    // lw $4 in EX, rt=$4 in ID: one stall, bubble, then WB forward on B
    task automatic test_load_use();
        clear_inputs();
        hz.writeRegAddrE = 5'd0; hz.regWriteE = 1'b1; hz.memToRegE = 1'b1; hz.rtD = 5'd0;
        #1;
        checks++; if (hz.stallD !== 1'b0) begin fails++; $display("FAIL lu_r0_stall: got %b exp 0", hz.stallD); end
        hz.writeRegAddrE = 5'd4; hz.rtD = 5'd4; hz.rsD = 5'd1; hz.branchTakenD = 1'b1;
        #1;
        checks++; if ({hz.stallF, hz.stallD, hz.flushE} !== 3'b111) begin fails++; $display("FAIL lu_stall: got %b exp 111", {hz.stallF, hz.stallD, hz.flushE}); end
        checks++; if (hz.flushD !== 1'b0) begin fails++; $display("FAIL lu_flushD: got %b exp 0", hz.flushD); end
        step();
        hz.writeRegAddrE = 5'd0; hz.regWriteE = 1'b0; hz.memToRegE = 1'b0; hz.branchTakenD = 1'b0;
        #1;
        checks++; if (hz.stallD !== 1'b0) begin fails++; $display("FAIL lu_release: got %b exp 0", hz.stallD); end
        checks++; if (hz.forwardBE !== 2'b00) begin fails++; $display("FAIL lu_bubble_B: got %b exp 00", hz.forwardBE); end
        step(); #1;
        checks++; if (hz.forwardBE !== 2'b10) begin fails++; $display("FAIL lu_fwd_B: got %b exp 10", hz.forwardBE); end
        checks++; if (hz.forwardAE !== 2'b00) begin fails++; $display("FAIL lu_fwd_A: got %b exp 00", hz.forwardAE); end
        clear_inputs();
        step(); step();
    endtask

    // mult in EX, mflo + taken branch in ID during all busy cycles
    task automatic test_md();
        clear_inputs();
        hz.mdStartE = 1'b1;
        #1;
        checks++; if (hz.mdBusy !== 1'b0) begin fails++; $display("FAIL md_pre_busy: got %b exp 0", hz.mdBusy); end
        step();
        hz.mdStartE = 1'b0; hz.hiloReadD = 1'b1; hz.branchTakenD = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            if (i == LAT - 1) hz.mdStartE = 1'b1;
            #1;
            checks++; if (hz.mdBusy !== 1'b1) begin fails++; $display("FAIL md_busy[%0d]: got %b exp 1", i, hz.mdBusy); end
            checks++; if (hz.mdDone !== (i == LAT - 1)) begin fails++; $display("FAIL md_done[%0d]: got %b exp %b", i, hz.mdDone, (i == LAT - 1)); end
            checks++; if ({hz.stallF, hz.stallD, hz.flushE} !== 3'b111) begin fails++; $display("FAIL md_stall[%0d]: got %b exp 111", i, {hz.stallF, hz.stallD, hz.flushE}); end
            checks++; if (hz.flushD !== 1'b0) begin fails++; $display("FAIL md_flushD[%0d]: got %b exp 0", i, hz.flushD); end
            step();
        end
        hz.mdStartE = 1'b0;
        #1;
        checks++; if ({hz.mdBusy, hz.mdDone} !== 2'b00) begin fails++; $display("FAIL md_end: got %b exp 00", {hz.mdBusy, hz.mdDone}); end
        checks++; if (hz.stallD !== 1'b0) begin fails++; $display("FAIL md_unstall: got %b exp 0", hz.stallD); end
        checks++; if (hz.flushD !== 1'b1) begin fails++; $display("FAIL md_deferred_flush: got %b exp 1", hz.flushD); end
        clear_inputs();
        step(); #1;
        checks++; if (hz.mdBusy !== 1'b0) begin fails++; $display("FAIL md_start_on_done: got %b exp 0", hz.mdBusy); end
        step();
    endtask

    // reset during busy cycle 2 aborts the operation and clears the shadows
    task automatic test_reset_mid();
        clear_inputs();
        hz.writeRegAddrE = 5'd7; hz.regWriteE = 1'b1; hz.rsD = 5'd7; hz.rtD = 5'd7; hz.mdStartE = 1'b1;
        step();
        hz.mdStartE = 1'b0;
        step(); #1;
        checks++; if (hz.forwardAE !== 2'b01) begin fails++; $display("FAIL rm_pre_fwd: got %b exp 01", hz.forwardAE); end
        checks++; if (hz.mdBusy !== 1'b1) begin fails++; $display("FAIL rm_pre_busy: got %b exp 1", hz.mdBusy); end
        rst = 1'b1;
        #1;
        checks++; if (hz.mdBusy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b exp 0", hz.mdBusy); end
        checks++; if ({hz.forwardAE, hz.forwardBE} !== 4'b0000) begin fails++; $display("FAIL rm_fwd: got %b exp 0000", {hz.forwardAE, hz.forwardBE}); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            checks++; if ({hz.mdBusy, hz.mdDone} !== 2'b00) begin fails++; $display("FAIL rm_after[%0d]: got %b exp 00", i, {hz.mdBusy, hz.mdDone}); end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_forward_mem_wb();
        test_priority_zero();
        test_load_use();
        test_md();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
